pc_ctrl: RTL and testbench

Fetch-side PC controller that sequences the program-counter register in the IFU. It arbitrates redirect requests (trap, jump, taken branch) against stall sources (load-use hazard, instruction-memory not ready). It drives the IFU's `stall_pc`, `pc_update_control` and `pc_update_val` and never asserts stall and update together. It also tracks post-redirect pipeline flushing and counts stall cycles.

---
 rtl/pc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pc_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-side program-counter sequencer.
// Arbitrates redirects (trap > jump > branch) against stall sources
// (load-use hazard, instruction memory busy). Holds a redirect while memory
// is busy, squashes IF/ID for FLUSH_CYCLES cycles after a redirect, and
// counts stalled cycles.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-low reset
//   imem_ready                    instruction memory accepts a fetch
//   ld_use_hazard                 decode requests a one-cycle hold
//   branch_taken/branch_target    taken branch from execute
//   jump_valid/jump_target        resolved JAL/JALR
//   trap_req/trap_vec             trap request (held until trap_ack)
//   trap_ack                      trap applied or latched this cycle
//   stall_pc                      IFU: hold PC
//   pc_update_control/_val        IFU: load redirect target
//   flush                         squash IF/ID
//   pending_valid                 redirect latched, waiting for memory
//   stall_cycles                  running count of stall_pc cycles
module pc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        imem_ready,
    input  logic        ld_use_hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    output logic        trap_ack,
    output logic        stall_pc,
    output logic        pc_update_control,
    output logic [31:0] pc_update_val,
    output logic        flush,
    output logic        pending_valid,
    output logic [31:0] stall_cycles
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    // Counter value loaded on a redirect; the redirect cycle is the first flush cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               USE_FLUSH  = (FLUSH_CYCLES > 32'd1);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pend_tgt, pend_tgt_nxt;
    logic              pend_trap, pend_trap_nxt;
    logic [CNT_W-1:0]  flush_cnt, flush_cnt_nxt;
    logic [XLEN-1:0]   stall_cnt, stall_cnt_nxt;

    logic              redir;
    logic [XLEN-1:0]   redir_raw;
    logic [XLEN-1:0]   redir_tgt;
    logic [XLEN-1:0]   trap_tgt;
    logic [XLEN-1:0]   hold_tgt;
    logic              hold_trap;

    logic              stall_c;
    logic              upd_c;
    logic [XLEN-1:0]   upd_val_c;
    logic              flush_c;
    logic              ack_c;

    // Redirect selection and next-state / output decode.
    always_comb begin
        state_nxt     = state;
        pend_tgt_nxt  = pend_tgt;
        pend_trap_nxt = pend_trap;
        flush_cnt_nxt = flush_cnt;
        stall_c       = 1'b0;
        upd_c         = 1'b0;
        upd_val_c     = '0;
        flush_c       = 1'b0;
        ack_c         = 1'b0;
        redir         = 1'b0;
        redir_raw     = '0;
        hold_tgt      = pend_tgt;
        hold_trap     = pend_trap;

        if (trap_req) begin
            redir     = 1'b1;
            redir_raw = trap_vec;
        end else if (jump_valid) begin
            redir     = 1'b1;
            redir_raw = jump_target;
        end else if (branch_taken) begin
            redir     = 1'b1;
            redir_raw = branch_target;
        end
        redir_tgt = redir_raw & ALIGN_MASK;
        trap_tgt  = trap_vec & ALIGN_MASK;

        case (state)
            ST_RUN: begin
                if (redir) begin
                    flush_c = 1'b1;
                    ack_c   = trap_req;
                    if (imem_ready) begin
                        upd_c     = 1'b1;
                        upd_val_c = redir_tgt;
                        if (USE_FLUSH) begin
                            state_nxt     = ST_FLUSH;
                            flush_cnt_nxt = CNT_LOAD;
                        end
                    end else begin
                        stall_c       = 1'b1;
                        pend_tgt_nxt  = redir_tgt;
                        pend_trap_nxt = trap_req;
                        state_nxt     = ST_HOLD;
                    end
                end else if (ld_use_hazard || !imem_ready) begin
                    stall_c = 1'b1;
                end
            end

            ST_HOLD: begin
                flush_c = 1'b1;
                // A trap replaces a latched jump/branch, but never an earlier trap.
                if (trap_req && !pend_trap) begin
                    ack_c     = 1'b1;
                    hold_tgt  = trap_tgt;
                    hold_trap = 1'b1;
                end
                if (imem_ready) begin
                    upd_c         = 1'b1;
                    upd_val_c     = hold_tgt;
                    pend_tgt_nxt  = '0;
                    pend_trap_nxt = 1'b0;
                    flush_cnt_nxt = CNT_LOAD;
                    state_nxt     = USE_FLUSH ? ST_FLUSH : ST_RUN;
                end else begin
                    stall_c       = 1'b1;
                    pend_tgt_nxt  = hold_tgt;
                    pend_trap_nxt = hold_trap;
                end
            end

            ST_FLUSH: begin
                flush_c = 1'b1;
                // Only traps matter here; other requests come from squashed instructions.
                if (trap_req) begin
                    ack_c = 1'b1;
                    if (imem_ready) begin
                        upd_c         = 1'b1;
                        upd_val_c     = trap_tgt;
                        flush_cnt_nxt = CNT_LOAD;
                    end else begin
                        stall_c       = 1'b1;
                        pend_tgt_nxt  = trap_tgt;
                        pend_trap_nxt = 1'b1;
                        state_nxt     = ST_HOLD;
                    end
                end else if (!imem_ready) begin
                    stall_c = 1'b1;
                end else begin
                    flush_cnt_nxt = flush_cnt - CNT_W'(1);
                    if (flush_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        stall_cnt_nxt = stall_c ? (stall_cnt + XLEN'(1)) : stall_cnt;
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= ST_RUN;
            pend_tgt  <= '0;
            pend_trap <= 1'b0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pend_tgt  <= pend_tgt_nxt;
            pend_trap <= pend_trap_nxt;
            flush_cnt <= flush_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    // Every output is forced low while reset is asserted.
    assign trap_ack          = i_rst & ack_c;
    assign stall_pc          = i_rst & stall_c;
    assign pc_update_control = i_rst & upd_c;
    assign pc_update_val     = i_rst ? upd_val_c : '0;
    assign flush             = i_rst & flush_c;
    assign pending_valid     = i_rst & (state == ST_HOLD);
    assign stall_cycles      = i_rst ? stall_cnt : '0;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed bench for pc_ctrl with a small IFU PC model.
module tb_pc_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        imem_ready;
    logic        ld_use_hazard;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        trap_ack;
    logic        stall_pc;
    logic        pc_update_control;
    logic [31:0] pc_update_val;
    logic        flush;
    logic        pending_valid;
    logic [31:0] stall_cycles;

    logic [31:0] pc;
    int          n_tests;
    int          n_fail;

    pc_ctrl #(.FLUSH_CYCLES(2)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .imem_ready        (imem_ready),
        .ld_use_hazard     (ld_use_hazard),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump_valid        (jump_valid),
        .jump_target       (jump_target),
        .trap_req          (trap_req),
        .trap_vec          (trap_vec),
        .trap_ack          (trap_ack),
        .stall_pc          (stall_pc),
        .pc_update_control (pc_update_control),
        .pc_update_val     (pc_update_val),
        .flush             (flush),
        .pending_valid     (pending_valid),
        .stall_cycles      (stall_cycles)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // IFU program counter driven by the controller outputs.
    always @(posedge i_clk) begin
        if (!i_rst)                 pc <= 32'h0;
        else if (pc_update_control) pc <= pc_update_val;
        else if (!stall_pc)         pc <= pc + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready    = 1'b1;
        ld_use_hazard = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;
        trap_req      = 1'b0;
        trap_vec      = 32'h0;
    endtask

    // Stall and update must never be asserted together.
    always @(negedge i_clk) begin
        if (n_tests > 0) check("stall_and_update", 32'(stall_pc & pc_update_control), 32'h0);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_rst   = 1'b0;
        idle_inputs();
        tick();

        // Outputs stay low during reset even with active requests.
        branch_taken  = 1'b1;
        branch_target = 32'h44;
        imem_ready    = 1'b0;
        ld_use_hazard = 1'b1;
        @(negedge i_clk);
        check("rst_stall", 32'(stall_pc), 32'h0);
        check("rst_upd", 32'(pc_update_control), 32'h0);
        check("rst_val", pc_update_val, 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_pend", 32'(pending_valid), 32'h0);
        check("rst_ack", 32'(trap_ack), 32'h0);
        check("rst_scnt", stall_cycles, 32'h0);
        tick();
        i_rst = 1'b1;
        idle_inputs();

        // Idle fetch: PC 0,4,8,12.
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check("idle_stall", 32'(stall_pc), 32'h0);
            check("idle_upd", 32'(pc_update_control), 32'h0);
            check("idle_flush", 32'(flush), 32'h0);
            check("idle_pc", pc, 32'(4 * i));
            tick();
        end
        check("idle_scnt", stall_cycles, 32'h0);

        // Jump beats branch; target is word-aligned.
        branch_taken = 1'b1; branch_target = 32'h100;
        jump_valid   = 1'b1; jump_target   = 32'h203;
        @(negedge i_clk);
        check("prio_upd", 32'(pc_update_control), 32'h1);
        check("prio_val", pc_update_val, 32'h200);
        check("prio_flush", 32'(flush), 32'h1);
        tick();
        check("prio_pc", pc, 32'h200);
        jump_valid = 1'b0; branch_target = 32'h300;
        @(negedge i_clk);
        check("flush_br_ign", 32'(pc_update_control), 32'h0);
        check("flush_cyc2", 32'(flush), 32'h1);
        tick();
        idle_inputs();
        @(negedge i_clk);
        check("flush_end", 32'(flush), 32'h0);
        tick();
        check("post_flush_pc", pc, 32'h208);

        // Jump while memory busy for 3 cycles.
        jump_valid = 1'b1; jump_target = 32'h80; imem_ready = 1'b0;
        @(negedge i_clk);
        check("hold_a_stall", 32'(stall_pc), 32'h1);
        check("hold_a_flush", 32'(flush), 32'h1);
        check("hold_a_pend", 32'(pending_valid), 32'h0);
        tick();
        jump_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check("hold_pend", 32'(pending_valid), 32'h1);
            check("hold_stall", 32'(stall_pc), 32'h1);
            tick();
        end
        imem_ready = 1'b1;
        @(negedge i_clk);
        check("hold_scnt", stall_cycles, 32'h3);
        check("hold_upd", 32'(pc_update_control), 32'h1);
        check("hold_val", pc_update_val, 32'h80);
        tick();
        check("hold_pc", pc, 32'h80);
        tick();

        // Trap overrides a latched jump; a second trap while one is pending is not acked.
        jump_valid = 1'b1; jump_target = 32'h80; imem_ready = 1'b0;
        tick();
        jump_valid = 1'b0; trap_req = 1'b1; trap_vec = 32'h1003;
        @(negedge i_clk);
        check("trap_ack", 32'(trap_ack), 32'h1);
        check("trap_pend", 32'(pending_valid), 32'h1);
        tick();
        trap_vec = 32'h2000;
        @(negedge i_clk);
        check("trap_noack", 32'(trap_ack), 32'h0);
        tick();
        trap_req = 1'b0; imem_ready = 1'b1;
        @(negedge i_clk);
        check("trap_upd", 32'(pc_update_control), 32'h1);
        check("trap_val", pc_update_val, 32'h1000);
        check("trap_ack_once", 32'(trap_ack), 32'h0);
        tick();
        check("trap_pc", pc, 32'h1000);
        check("trap_scnt", stall_cycles, 32'h6);
        tick();

        // Load-use hazard alone, then concurrent with a branch.
        ld_use_hazard = 1'b1;
        @(negedge i_clk);
        check("ldu_stall", 32'(stall_pc), 32'h1);
        check("ldu_flush", 32'(flush), 32'h0);
        tick();
        check("ldu_pc", pc, 32'h1004);
        branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge i_clk);
        check("ldu_br_upd", 32'(pc_update_control), 32'h1);
        check("ldu_br_val", pc_update_val, 32'h40);
        tick();
        check("ldu_br_pc", pc, 32'h40);

        // Trap during FLUSH is applied and restarts the flush window.
        idle_inputs();
        trap_req = 1'b1; trap_vec = 32'h500;
        @(negedge i_clk);
        check("ftrap_ack", 32'(trap_ack), 32'h1);
        check("ftrap_val", pc_update_val, 32'h500);
        tick();
        trap_req = 1'b0;
        @(negedge i_clk);
        check("ftrap_flush", 32'(flush), 32'h1);
        check("ftrap_upd", 32'(pc_update_control), 32'h0);
        tick();
        @(negedge i_clk);
        check("ftrap_end", 32'(flush), 32'h0);
        tick();

        // Memory stall during FLUSH freezes the counter.
        branch_taken = 1'b1; branch_target = 32'h700;
        tick();
        branch_taken = 1'b0; imem_ready = 1'b0;
        @(negedge i_clk);
        check("ffrz_stall", 32'(stall_pc), 32'h1);
        tick();
        imem_ready = 1'b1;
        @(negedge i_clk);
        check("ffrz_flush", 32'(flush), 32'h1);
        tick();
        @(negedge i_clk);
        check("ffrz_end", 32'(flush), 32'h0);
        check("ffrz_scnt", stall_cycles, 32'h8);
        tick();

        // Stall counter wraps.
        force dut.stall_cnt = 32'hFFFF_FFFF;
        ld_use_hazard = 1'b1;
        @(negedge i_clk);
        check("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
        release dut.stall_cnt;
        tick();
        ld_use_hazard = 1'b0;
        @(negedge i_clk);
        check("wrap_post", stall_cycles, 32'h0);
        tick();

        // Reset mid-FLUSH.
        branch_taken = 1'b1; branch_target = 32'h600;
        tick();
        branch_taken = 1'b0; imem_ready = 1'b0; i_rst = 1'b0;
        @(negedge i_clk);
        check("rflush_stall", 32'(stall_pc), 32'h0);
        check("rflush_flush", 32'(flush), 32'h0);
        tick();
        i_rst = 1'b1; imem_ready = 1'b1;
        @(negedge i_clk);
        check("rflush_run", 32'(flush), 32'h0);
        check("rflush_upd", 32'(pc_update_control), 32'h0);
        tick();

        // Reset mid-HOLD discards the pending redirect.
        jump_valid = 1'b1; jump_target = 32'h900; imem_ready = 1'b0;
        tick();
        jump_valid = 1'b0; i_rst = 1'b0;
        @(negedge i_clk);
        check("rhold_pend", 32'(pending_valid), 32'h0);
        tick();
        i_rst = 1'b1; imem_ready = 1'b1;
        @(negedge i_clk);
        check("rhold_upd", 32'(pc_update_control), 32'h0);
        check("rhold_flush", 32'(flush), 32'h0);
        check("rhold_scnt", stall_cycles, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
